// File: rtl/posit_stream_checker.sv
// Checks streamed posit results against queued golden values and keeps error statistics.
// Latency: compare results register one cycle after dut_done; no backpressure, overflow/orphan are flagged.
module posit_stream_checker #(
    parameter int N       = 8,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16,
    parameter int TOL     = 0
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             start,
    input  logic             exp_valid,
    input  logic [N-1:0]     exp_data,
    input  logic             dut_done,
    input  logic [N-1:0]     dut_result,
    input  logic             dut_inf,
    input  logic             dut_zero,
    output logic             err_valid,
    output logic [N-1:0]     err_diff,
    output logic [CNT_W-1:0] err_index,
    output logic [CNT_W-1:0] checked_count,
    output logic [CNT_W-1:0] error_count,
    output logic [N-1:0]     max_diff,
    output logic [CNT_W-1:0] first_err_index,
    output logic             first_err_valid,
    output logic             orphan,
    output logic             overflow,
    output logic [CNT_W-1:0] missing_count,
    output logic             busy,
    output logic             finished
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [N-1:0]     NAR        = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]     TOL_V      = N'(TOL);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2*LATENCY+3);
    localparam logic [AW:0]      FULL_OCC   = (AW+1)'(DEPTH);

    logic [1:0]       state;
    logic             start_q;
    logic [CNT_W-1:0] drain_cnt;
    logic [N-1:0]     mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      occ, occ_nxt;

    logic         start_run, push_req, pop_req, empty, full, push, pop;
    logic         mismatch, drain_to;
    logic [N-1:0] head, diff;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        start_run = (state == S_IDLE) && start && !start_q;
        push_req  = (state == S_RUN) && exp_valid;
        pop_req   = ((state == S_RUN) || (state == S_DRAIN)) && dut_done;
        empty     = (occ == '0);
        full      = (occ == FULL_OCC);
        pop       = pop_req && !empty;
        // A simultaneous pop frees the slot, so a full FIFO still takes the push.
        push      = push_req && (!full || pop);
        occ_nxt   = occ;
        if (push && !pop)
            occ_nxt = occ + 1'b1;
        else if (pop && !push)
            occ_nxt = occ - 1'b1;
        head      = mem[rd_ptr];
        diff      = (head > dut_result) ? head - dut_result : dut_result - head;
        mismatch  = (diff > TOL_V) || (dut_inf && (head != NAR)) || (dut_zero && (head != '0));
        drain_to  = (state == S_DRAIN) && (drain_cnt == DRAIN_LAST);
    end

    assign busy     = (state != S_IDLE);
    assign finished = (state == S_DONE);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            start_q   <= 1'b0;
            drain_cnt <= '0;
        end else begin
            start_q <= start;
            case (state)
                S_IDLE:  if (start_run) state <= S_RUN;
                S_RUN: begin
                    drain_cnt <= '0;
                    if (!start) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                    if (empty || drain_to) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= exp_data;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            occ             <= '0;
            err_valid       <= 1'b0;
            err_diff        <= '0;
            err_index       <= '0;
            checked_count   <= '0;
            error_count     <= '0;
            max_diff        <= '0;
            first_err_index <= '0;
            first_err_valid <= 1'b0;
            orphan          <= 1'b0;
            overflow        <= 1'b0;
            missing_count   <= '0;
        end else if (start_run) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            occ             <= '0;
            err_valid       <= 1'b0;
            err_diff        <= '0;
            err_index       <= '0;
            checked_count   <= '0;
            error_count     <= '0;
            max_diff        <= '0;
            first_err_index <= '0;
            first_err_valid <= 1'b0;
            orphan          <= 1'b0;
            overflow        <= 1'b0;
            missing_count   <= '0;
        end else begin
            err_valid <= 1'b0;
            occ       <= occ_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop_req && empty) orphan <= 1'b1;
            if (push_req && full && !pop) overflow <= 1'b1;
            if (pop) begin
                rd_ptr        <= rd_ptr + 1'b1;
                checked_count <= sat_inc(checked_count);
                err_diff      <= diff;
                err_index     <= checked_count;
                if (diff > max_diff) max_diff <= diff;
                if (mismatch) begin
                    err_valid   <= 1'b1;
                    error_count <= sat_inc(error_count);
                    if (!first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_index <= checked_count;
                    end
                end
            end
            if (drain_to && !empty) missing_count <= CNT_W'(occ_nxt);
        end
    end

endmodule

// File: tb/tb_posit_stream_checker.sv
// Directed bench for posit_stream_checker: golden vectors with hand-computed expectations.
module tb_posit_stream_checker;

    localparam int LAT = 4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        start, exp_valid, dut_done, dut_inf, dut_zero;
    logic [7:0]  exp_data, dut_result;
    logic        err_valid, first_err_valid, orphan, overflow, busy, finished;
    logic [7:0]  err_diff, max_diff;
    logic [15:0] err_index, checked_count, error_count, first_err_index, missing_count;

    int checks = 0;
    int errors = 0;
    int n_pulse, n_fin, drain_obs, tcur, pulse_t;
    logic [7:0]  pulse_diff [8];
    logic [15:0] pulse_idx  [8];
    logic [7:0]  ev [16];
    logic [7:0]  rv [16];
    logic        rinf  [16];
    logic        rzero [16];

    posit_stream_checker dut (
        .aclk(aclk), .aresetn(aresetn), .start(start),
        .exp_valid(exp_valid), .exp_data(exp_data),
        .dut_done(dut_done), .dut_result(dut_result), .dut_inf(dut_inf), .dut_zero(dut_zero),
        .err_valid(err_valid), .err_diff(err_diff), .err_index(err_index),
        .checked_count(checked_count), .error_count(error_count), .max_diff(max_diff),
        .first_err_index(first_err_index), .first_err_valid(first_err_valid),
        .orphan(orphan), .overflow(overflow), .missing_count(missing_count),
        .busy(busy), .finished(finished)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
        if (err_valid) begin
            if (n_pulse < 8) begin
                pulse_diff[n_pulse] = err_diff;
                pulse_idx[n_pulse]  = err_index;
            end
            pulse_t = tcur;
            n_pulse++;
        end
        if (finished) n_fin++;
        if (busy && !finished && !start) drain_obs++;
    endtask

    task automatic idle_inputs();
        exp_valid = 0; exp_data = '0;
        dut_done = 0; dut_result = '0; dut_inf = 0; dut_zero = 0;
    endtask

    task automatic clr_vec();
        for (int i = 0; i < 16; i++) begin
            ev[i] = 8'(i * 7 + 3); rv[i] = 8'(i * 7 + 3); rinf[i] = 0; rzero[i] = 0;
        end
    endtask

    task automatic wait_finish();
        idle_inputs();
        start = 0;
        for (int k = 0; k < 40 && n_fin == 0; k++) step();
        step();
    endtask

    // DUT model: every result returns LAT cycles after its issue; the last 'drop' never return.
    task automatic run_stream(input int n, input int drop);
        n_pulse = 0; n_fin = 0; drain_obs = 0; pulse_t = -1;
        start = 1; tcur = -1;
        step();
        for (int t = 0; t < n + LAT; t++) begin
            tcur = t;
            start = (t < n);
            exp_valid = (t < n);
            exp_data = (t < n) ? ev[t] : 8'h00;
            if (t >= LAT && (t - LAT) < (n - drop)) begin
                dut_done = 1; dut_result = rv[t-LAT]; dut_inf = rinf[t-LAT]; dut_zero = rzero[t-LAT];
            end else begin
                dut_done = 0; dut_result = '0; dut_inf = 0; dut_zero = 0;
            end
            step();
        end
        wait_finish();
    endtask

    task automatic chk_all_zero(input string p);
        check({p, "_err_valid"}, err_valid, 0);
        check({p, "_err_diff"}, err_diff, 0);
        check({p, "_err_index"}, err_index, 0);
        check({p, "_checked"}, checked_count, 0);
        check({p, "_errors"}, error_count, 0);
        check({p, "_max_diff"}, max_diff, 0);
        check({p, "_first_idx"}, first_err_index, 0);
        check({p, "_first_vld"}, first_err_valid, 0);
        check({p, "_orphan"}, orphan, 0);
        check({p, "_overflow"}, overflow, 0);
        check({p, "_missing"}, missing_count, 0);
        check({p, "_busy"}, busy, 0);
        check({p, "_finished"}, finished, 0);
    endtask

    initial begin
        // Reset with random inputs, then idle with start low.
        aresetn = 0; start = 0;
        for (int i = 0; i < 4; i++) begin
            exp_valid = 1'($urandom); exp_data = 8'($urandom);
            dut_done = 1'($urandom); dut_result = 8'($urandom);
            dut_inf = 1'($urandom); dut_zero = 1'($urandom);
            #3;
        end
        chk_all_zero("rst");
        @(posedge aclk); #1;
        aresetn = 1;
        for (int i = 0; i < 10; i++) begin
            exp_valid = 1'($urandom); exp_data = 8'($urandom);
            dut_done = 1'($urandom); dut_result = 8'($urandom);
            step();
        end
        chk_all_zero("idle");
        idle_inputs();

        // Clean 10-entry stream.
        clr_vec();
        run_stream(10, 0);
        check("clean_checked", checked_count, 10);
        check("clean_errors", error_count, 0);
        check("clean_max_diff", max_diff, 0);
        check("clean_finished", n_fin, 1);
        check("clean_missing", missing_count, 0);
        check("clean_pulses", n_pulse, 0);
        check("clean_busy_after", busy, 0);

        // Single mismatch at entry 5.
        clr_vec();
        ev[5] = 8'h40; rv[5] = 8'h43;
        run_stream(8, 0);
        check("mm_pulses", n_pulse, 1);
        check("mm_pulse_time", pulse_t, 5 + LAT);
        check("mm_err_diff", pulse_diff[0], 8'h03);
        check("mm_err_index", pulse_idx[0], 5);
        check("mm_first_idx", first_err_index, 5);
        check("mm_first_vld", first_err_valid, 1);
        check("mm_errors", error_count, 1);
        check("mm_max_diff", max_diff, 8'h03);
        check("mm_checked", checked_count, 8);

        // Reverse difference, NaR and zero flags.
        clr_vec();
        ev[0] = 8'h10; rv[0] = 8'hF0;
        ev[1] = 8'h80; rv[1] = 8'h80; rinf[1] = 1;
        ev[2] = 8'h01; rv[2] = 8'h00; rzero[2] = 1;
        run_stream(3, 0);
        check("flag_pulses", n_pulse, 2);
        check("flag_rev_diff", pulse_diff[0], 8'hE0);
        check("flag_rev_idx", pulse_idx[0], 0);
        check("flag_zero_diff", pulse_diff[1], 8'h01);
        check("flag_zero_idx", pulse_idx[1], 2);
        check("flag_errors", error_count, 2);
        check("flag_max_diff", max_diff, 8'hE0);
        check("flag_first_idx", first_err_index, 0);
        check("flag_last_diff", err_diff, 8'h01);

        // Orphan (with a push in the same cycle), fill, full push+pop, then overflow.
        n_fin = 0;
        start = 1; step();
        dut_done = 1; dut_result = 8'h11; exp_valid = 1; exp_data = 8'h11;
        step();
        check("orph_flag", orphan, 1);
        check("orph_checked", checked_count, 0);
        dut_done = 0;
        for (int i = 1; i < 8; i++) begin
            exp_data = 8'(8'h11 + i);
            step();
        end
        check("full_no_ovf", overflow, 0);
        exp_data = 8'h55; dut_done = 1; dut_result = 8'h11;
        step();
        check("full_pushpop_ovf", overflow, 0);
        check("full_pushpop_checked", checked_count, 1);
        check("full_pushpop_errors", error_count, 0);
        dut_done = 0; exp_data = 8'h66;
        step();
        check("ovf_flag", overflow, 1);
        wait_finish();
        check("ovf_finished", n_fin, 1);
        check("ovf_missing", missing_count, 8);

        // Two entries never returned: drain times out.
        clr_vec();
        run_stream(6, 2);
        check("drop_checked", checked_count, 4);
        check("drop_missing", missing_count, 2);
        check("drop_drain_len", drain_obs, 2 * LAT + 4);
        check("drop_finished", n_fin, 1);
        check("drop_orphan_clr", orphan, 0);
        check("drop_ovf_clr", overflow, 0);

        // Reset mid-run with entries still queued.
        start = 1; step();
        for (int i = 0; i < 5; i++) begin
            exp_valid = 1; exp_data = 8'(8'hA0 + i);
            step();
        end
        exp_valid = 0;
        for (int i = 0; i < 3; i++) begin
            dut_done = 1; dut_result = 8'(8'hA0 + i);
            step();
        end
        idle_inputs();
        check("mid_checked_pre", checked_count, 3);
        aresetn = 0; start = 0;
        #2;
        chk_all_zero("mid_rst");
        @(posedge aclk); #1;
        aresetn = 1;
        step();
        clr_vec();
        for (int i = 0; i < 4; i++) begin
            ev[i] = 8'(8'h05 + i); rv[i] = 8'(8'h05 + i);
        end
        run_stream(4, 0);
        check("post_checked", checked_count, 4);
        check("post_errors", error_count, 0);
        check("post_missing", missing_count, 0);
        check("post_finished", n_fin, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
